// File: rtl/branch_resolve_queue.sv
// -----------------------------------------------------------------------------
// branch_resolve_queue
//
// Tracks in-flight predicted branches between the IF-stage gshare predictor and
// the EX stage. IF pushes one prediction record per branch. The records are
// resolved strictly in program order. Each accepted resolve produces a
// registered PHT/GHR training pulse. A misprediction also produces a registered
// fetch redirect and kills every younger record still in the queue.
//
// Optional feature macro: BRQ_PERF_EN adds two saturating performance counters
// (perf_branches, perf_mispredicts).
//
// Ports
//   clk, rst_n        rising-edge clock, synchronous active-low reset
//   if_push_valid     IF offers a prediction record
//   if_push_ready     queue not full
//   if_pc             branch PC
//   if_pred_taken     predicted direction
//   if_pht_idx        PHT index used for the prediction
//   if_pred_target    predicted target (only meaningful when predicted taken)
//   ex_resolve_valid  EX resolves the oldest in-flight branch
//   ex_taken          actual direction
//   ex_target         actual taken target
//   ext_flush         trap/exception kill of all in-flight records
//   ex_update_en      training strobe (1-cycle pulse)
//   ex_actual_taken   training direction
//   pht_idx_ex        training PHT index
//   redirect_valid    fetch redirect strobe (1-cycle pulse)
//   redirect_pc       corrected fetch PC
//   resolve_err       sticky: resolve arrived while the queue was empty
//   count             current occupancy
//   perf_branches     (BRQ_PERF_EN) accepted resolves, saturating
//   perf_mispredicts  (BRQ_PERF_EN) mispredicts, saturating
// -----------------------------------------------------------------------------
module branch_resolve_queue #(
   parameter int DEPTH    = 4,
   parameter int PHT_BITS = 5
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      if_push_valid,
   output logic                      if_push_ready,
   input  logic [31:0]               if_pc,
   input  logic                      if_pred_taken,
   input  logic [PHT_BITS-1:0]       if_pht_idx,
   input  logic [31:0]               if_pred_target,
   input  logic                      ex_resolve_valid,
   input  logic                      ex_taken,
   input  logic [31:0]               ex_target,
   input  logic                      ext_flush,
   output logic                      ex_update_en,
   output logic                      ex_actual_taken,
   output logic [PHT_BITS-1:0]       pht_idx_ex,
   output logic                      redirect_valid,
   output logic [31:0]               redirect_pc,
   output logic                      resolve_err,
   output logic [$clog2(DEPTH):0]    count
`ifdef BRQ_PERF_EN
   ,
   output logic [31:0]               perf_branches,
   output logic [31:0]               perf_mispredicts
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int PW = AW + 1;
   localparam logic [PW-1:0] PTR_ONE = PW'(1);

   // Record storage; contents are don't-care until written, so no reset.
   logic [31:0]          pc_mem   [DEPTH];
   logic                 taken_mem[DEPTH];
   logic [PHT_BITS-1:0]  idx_mem  [DEPTH];
   logic [31:0]          tgt_mem  [DEPTH];

   logic [PW-1:0] wr_ptr, rd_ptr, wr_nxt, rd_nxt;
   logic          full, empty;
   logic          res_acc, mispred, pop_ok, push_acc;
   logic [31:0]   head_pc, head_tgt, correct_pc;
   logic          head_taken;
   logic [PHT_BITS-1:0] head_idx;

   logic                upd_vld_p1, taken_p1, redir_vld_p1, err_p1;
   logic [PHT_BITS-1:0] idx_p1;
   logic [31:0]         redir_pc_p1;

   assign full  = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
   assign empty = (wr_ptr == rd_ptr);
   assign count = wr_ptr - rd_ptr;
   assign if_push_ready = !full;

   assign head_pc    = pc_mem[rd_ptr[AW-1:0]];
   assign head_taken = taken_mem[rd_ptr[AW-1:0]];
   assign head_idx   = idx_mem[rd_ptr[AW-1:0]];
   assign head_tgt   = tgt_mem[rd_ptr[AW-1:0]];

   // Flush outranks resolve; a resolve on an empty queue is not accepted.
   assign res_acc = ex_resolve_valid && !empty && !ext_flush;
   // The predicted target only matters for branches that were actually taken.
   assign mispred = res_acc &&
                    ((head_taken != ex_taken) || (ex_taken && (head_tgt != ex_target)));
   assign pop_ok  = res_acc && !mispred;
   assign correct_pc = ex_taken ? ex_target : head_pc + 32'd4;

   // A correct pop frees the slot in the same cycle, so a push is taken even
   // when full; ready deliberately ignores this to stay free of the EX path.
   // Pushes during a mispredict or flush are wrong-path and are dropped.
   assign push_acc = if_push_valid && !ext_flush && !mispred && (!full || pop_ok);

   always_comb begin
      rd_nxt = rd_ptr;
      wr_nxt = wr_ptr;
      if (ext_flush) begin
         wr_nxt = rd_ptr;
      end else if (mispred) begin
         rd_nxt = rd_ptr + PTR_ONE;
         wr_nxt = rd_ptr + PTR_ONE;
      end else begin
         if (res_acc)  rd_nxt = rd_ptr + PTR_ONE;
         if (push_acc) wr_nxt = wr_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_acc) begin
         pc_mem[wr_ptr[AW-1:0]]    <= if_pc;
         taken_mem[wr_ptr[AW-1:0]] <= if_pred_taken;
         idx_mem[wr_ptr[AW-1:0]]   <= if_pht_idx;
         tgt_mem[wr_ptr[AW-1:0]]   <= if_pred_target;
      end
   end

   // ---- stage p1: registered training / redirect outputs ----
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wr_ptr       <= '0;
         rd_ptr       <= '0;
         upd_vld_p1   <= 1'b0;
         taken_p1     <= 1'b0;
         idx_p1       <= '0;
         redir_vld_p1 <= 1'b0;
         redir_pc_p1  <= '0;
         err_p1       <= 1'b0;
      end else begin
         wr_ptr       <= wr_nxt;
         rd_ptr       <= rd_nxt;
         upd_vld_p1   <= res_acc;
         taken_p1     <= res_acc & ex_taken;
         idx_p1       <= res_acc ? head_idx : '0;
         redir_vld_p1 <= mispred;
         redir_pc_p1  <= mispred ? correct_pc : '0;
         if (ex_resolve_valid && empty && !ext_flush)
            err_p1 <= 1'b1;
      end
   end

   assign ex_update_en    = upd_vld_p1;
   assign ex_actual_taken = taken_p1;
   assign pht_idx_ex      = idx_p1;
   assign redirect_valid  = redir_vld_p1;
   assign redirect_pc     = redir_pc_p1;
   assign resolve_err     = err_p1;

`ifdef BRQ_PERF_EN
   function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
      return (en && (v != 32'hFFFF_FFFF)) ? v + 32'd1 : v;
   endfunction

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         perf_branches    <= '0;
         perf_mispredicts <= '0;
      end else begin
         perf_branches    <= sat_inc(perf_branches, res_acc);
         perf_mispredicts <= sat_inc(perf_mispredicts, mispred);
      end
   end
`endif

endmodule

// File: tb/tb_branch_resolve_queue.sv
// Scoreboard bench for branch_resolve_queue (DEPTH=4, PHT_BITS=5).
module tb_branch_resolve_queue;

   logic        clk;
   logic        rst_n;
   logic        if_push_valid;
   logic        if_push_ready;
   logic [31:0] if_pc;
   logic        if_pred_taken;
   logic [4:0]  if_pht_idx;
   logic [31:0] if_pred_target;
   logic        ex_resolve_valid;
   logic        ex_taken;
   logic [31:0] ex_target;
   logic        ext_flush;
   logic        ex_update_en;
   logic        ex_actual_taken;
   logic [4:0]  pht_idx_ex;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        resolve_err;
   logic [2:0]  count;
`ifdef BRQ_PERF_EN
   logic [31:0] perf_branches;
   logic [31:0] perf_mispredicts;
`endif

   branch_resolve_queue #(.DEPTH(4), .PHT_BITS(5)) dut (
      .clk              (clk),
      .rst_n            (rst_n),
      .if_push_valid    (if_push_valid),
      .if_push_ready    (if_push_ready),
      .if_pc            (if_pc),
      .if_pred_taken    (if_pred_taken),
      .if_pht_idx       (if_pht_idx),
      .if_pred_target   (if_pred_target),
      .ex_resolve_valid (ex_resolve_valid),
      .ex_taken         (ex_taken),
      .ex_target        (ex_target),
      .ext_flush        (ext_flush),
      .ex_update_en     (ex_update_en),
      .ex_actual_taken  (ex_actual_taken),
      .pht_idx_ex       (pht_idx_ex),
      .redirect_valid   (redirect_valid),
      .redirect_pc      (redirect_pc),
      .resolve_err      (resolve_err),
      .count            (count)
`ifdef BRQ_PERF_EN
      ,
      .perf_branches    (perf_branches),
      .perf_mispredicts (perf_mispredicts)
`endif
   );

   typedef struct {
      logic        taken;
      logic [4:0]  idx;
      logic        redir;
      logic [31:0] rpc;
   } exp_t;

   exp_t sb[$];
   exp_t mon_e;
   int   n_vec = 0;
   int   n_err = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, vectors=%0d", n_vec);
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
      end
   endtask

   // Monitor: every output pulse must match the oldest expected response.
   always @(negedge clk) begin
      if (ex_update_en || redirect_valid) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_pulse: got upd=%0b redir=%0b idx=%0d, expected no pulse",
                     ex_update_en, redirect_valid, pht_idx_ex);
         end else begin
            mon_e = sb.pop_front();
            chk("upd_en",      {31'd0, ex_update_en},    32'd1);
            chk("upd_taken",   {31'd0, ex_actual_taken}, {31'd0, mon_e.taken});
            chk("upd_idx",     {27'd0, pht_idx_ex},      {27'd0, mon_e.idx});
            chk("redir_valid", {31'd0, redirect_valid},  {31'd0, mon_e.redir});
            chk("redir_pc",    redirect_pc,              mon_e.rpc);
         end
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic set_push(input logic [31:0] pc, input logic t, input logic [4:0] idx,
                           input logic [31:0] tgt);
      if_push_valid  = 1'b1;
      if_pc          = pc;
      if_pred_taken  = t;
      if_pht_idx     = idx;
      if_pred_target = tgt;
   endtask

   task automatic push(input logic [31:0] pc, input logic t, input logic [4:0] idx,
                       input logic [31:0] tgt);
      set_push(pc, t, idx, tgt);
      cyc();
      if_push_valid = 1'b0;
   endtask

   task automatic resolve(input logic t, input logic [31:0] tgt);
      ex_resolve_valid = 1'b1;
      ex_taken         = t;
      ex_target        = tgt;
      cyc();
      ex_resolve_valid = 1'b0;
   endtask

   task automatic exp_upd(input logic t, input logic [4:0] idx, input logic r,
                          input logic [31:0] rpc);
      exp_t e;
      e.taken = t;
      e.idx   = idx;
      e.redir = r;
      e.rpc   = rpc;
      sb.push_back(e);
   endtask

   initial begin
      rst_n = 1'b0;
      if_push_valid = 1'b0; if_pc = '0; if_pred_taken = 1'b0; if_pht_idx = '0;
      if_pred_target = '0; ex_resolve_valid = 1'b0; ex_taken = 1'b0; ex_target = '0;
      ext_flush = 1'b0;
      repeat (2) cyc();

      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_ready", {31'd0, if_push_ready}, 32'd1);
      chk("rst_err",   {31'd0, resolve_err}, 32'd0);
      chk("rst_upd",   {31'd0, ex_update_en}, 32'd0);
      chk("rst_redir", {31'd0, redirect_valid}, 32'd0);
      rst_n = 1'b1;
      cyc();

      // Correctly predicted taken branch.
      push(32'h100, 1'b1, 5'd5, 32'h200);
      chk("t1_count_push", {29'd0, count}, 32'd1);
      exp_upd(1'b1, 5'd5, 1'b0, 32'h0);
      resolve(1'b1, 32'h200);
      chk("t1_count", {29'd0, count}, 32'd0);

      // Predicted not taken, actually taken.
      push(32'h100, 1'b0, 5'd3, 32'h0);
      exp_upd(1'b1, 5'd3, 1'b1, 32'h180);
      resolve(1'b1, 32'h180);
      chk("t2_count", {29'd0, count}, 32'd0);

      // Predicted taken, actually not taken: redirect to pc+4.
      push(32'h1000, 1'b1, 5'd7, 32'h2000);
      exp_upd(1'b0, 5'd7, 1'b1, 32'h1004);
      resolve(1'b0, 32'h0);

      // Right direction, wrong target.
      push(32'h2000, 1'b1, 5'd9, 32'h300);
      exp_upd(1'b1, 5'd9, 1'b1, 32'h304);
      resolve(1'b1, 32'h304);

      // pc+4 wraps to zero on a mispredict.
      push(32'hFFFF_FFFC, 1'b1, 5'd31, 32'h40);
      exp_upd(1'b0, 5'd31, 1'b1, 32'h0);
      resolve(1'b0, 32'h0);

      // Not-taken/not-taken: stale predicted and actual targets are ignored.
      push(32'h700, 1'b0, 5'd17, 32'hDEAD);
      exp_upd(1'b0, 5'd17, 1'b0, 32'h0);
      resolve(1'b0, 32'h1234);

      // Fill to DEPTH, reject a 5th push, then pop+push while full.
      for (int i = 0; i < 4; i++)
         push(32'h400 + 32'(4 * i), 1'b0, 5'(10 + i), 32'h0);
      chk("t3_ready_full", {31'd0, if_push_ready}, 32'd0);
      chk("t3_count_full", {29'd0, count}, 32'd4);
      push(32'h480, 1'b0, 5'd20, 32'h0);
      chk("t3_count_5th", {29'd0, count}, 32'd4);
      set_push(32'h500, 1'b0, 5'd14, 32'h0);
      exp_upd(1'b0, 5'd10, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);
      if_push_valid = 1'b0;
      chk("t3_count_swap", {29'd0, count}, 32'd4);
      // Back-to-back resolves drain the rest in order.
      ex_resolve_valid = 1'b1;
      ex_taken         = 1'b0;
      for (int i = 0; i < 4; i++) begin
         exp_upd(1'b0, 5'(11 + i), 1'b0, 32'h0);
         cyc();
      end
      ex_resolve_valid = 1'b0;
      chk("t3_count_drain", {29'd0, count}, 32'd0);

      // Mispredict with a same-cycle push: younger entries and push discarded.
      for (int i = 0; i < 3; i++)
         push(32'h600 + 32'(4 * i), 1'b0, 5'(1 + i), 32'h0);
      set_push(32'h60C, 1'b0, 5'd4, 32'h0);
      exp_upd(1'b1, 5'd1, 1'b1, 32'h500);
      resolve(1'b1, 32'h500);
      if_push_valid = 1'b0;
      chk("t4_count", {29'd0, count}, 32'd0);
      chk("t4_err_before", {31'd0, resolve_err}, 32'd0);
      resolve(1'b0, 32'h0);
      chk("t4_err", {31'd0, resolve_err}, 32'd1);
      chk("t4_ready", {31'd0, if_push_ready}, 32'd1);

      // ext_flush beats a same-cycle resolve.
      push(32'h900, 1'b0, 5'd5, 32'h0);
      push(32'h904, 1'b0, 5'd6, 32'h0);
      ext_flush = 1'b1;
      resolve(1'b0, 32'h0);
      ext_flush = 1'b0;
      chk("t5_count", {29'd0, count}, 32'd0);
      chk("t5_err_sticky", {31'd0, resolve_err}, 32'd1);
      push(32'h908, 1'b0, 5'd8, 32'h0);
      exp_upd(1'b0, 5'd8, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);

      // Reset mid-stream suppresses a pending mispredict.
      push(32'hA00, 1'b0, 5'd21, 32'h0);
      push(32'hA04, 1'b0, 5'd22, 32'h0);
      rst_n = 1'b0;
      resolve(1'b1, 32'h999);
      chk("t6_count", {29'd0, count}, 32'd0);
      chk("t6_ready", {31'd0, if_push_ready}, 32'd1);
      chk("t6_err", {31'd0, resolve_err}, 32'd0);
      chk("t6_upd", {31'd0, ex_update_en}, 32'd0);
      chk("t6_redir", {31'd0, redirect_valid}, 32'd0);
      chk("t6_redir_pc", redirect_pc, 32'd0);
      chk("t6_idx", {27'd0, pht_idx_ex}, 32'd0);
      cyc();
      rst_n = 1'b1;
      cyc();

      // Three resolves, one mispredict.
      push(32'h800, 1'b0, 5'd1, 32'h0);
      exp_upd(1'b0, 5'd1, 1'b0, 32'h0);
      resolve(1'b0, 32'h0);
      push(32'h804, 1'b0, 5'd2, 32'h0);
      exp_upd(1'b1, 5'd2, 1'b1, 32'h900);
      resolve(1'b1, 32'h900);
      push(32'h808, 1'b1, 5'd3, 32'h10);
      exp_upd(1'b1, 5'd3, 1'b0, 32'h0);
      resolve(1'b1, 32'h10);
`ifdef BRQ_PERF_EN
      chk("perf_branches", perf_branches, 32'd3);
      chk("perf_mispredicts", perf_mispredicts, 32'd1);
`endif

      repeat (2) cyc();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/branch_resolve_queue.md
# branch_resolve_queue

In-flight branch tracker between the IF-stage gshare predictor and the EX stage. It captures each IF prediction record: PHT index, predicted direction, predicted target and PC. It holds records in program order until EX resolves the branch. It then produces the registered PHT/GHR training update and, on a misprediction, a fetch redirect plus a flush of all younger in-flight records.

## Interface
- `DEPTH`, default 4: in-flight branch records; power of two, at least 2.
- `PHT_BITS`, default 5: PHT index width; must match the predictor.
- `clk` input, 1: rising-edge clock.
- `rst_n` input, 1: synchronous, active-low reset.
- `if_push_valid` input, 1: IF presents a predicted branch record.
- `if_push_ready` output, 1: queue can accept a record; equals `!full`.
- `if_pc` input, 32: PC of the branch.
- `if_pred_taken` input, 1: predicted direction.
- `if_pht_idx` input, PHT_BITS: PHT index used for the prediction.
- `if_pred_target` input, 32: predicted target; meaningful only when predicted taken.
- `ex_resolve_valid` input, 1: EX resolves the oldest in-flight branch this cycle.
- `ex_taken` input, 1: actual direction.
- `ex_target` input, 32: actual taken target.
- `ext_flush` input, 1: trap/exception kill of all in-flight records.
- `ex_update_en` output, 1: training strobe to the predictor.
- `ex_actual_taken` output, 1: training direction.
- `pht_idx_ex` output, PHT_BITS: training index.
- `redirect_valid` output, 1: fetch redirect strobe.
- `redirect_pc` output, 32: corrected fetch PC.
- `resolve_err` output, 1: sticky flag; resolve arrived while the queue was empty.
- `count` output, $clog2(DEPTH)+1: current occupancy.

## Operation
- Storage is a circular buffer of DEPTH records {pc, pred_taken, pht_idx, pred_target}.
- Read and write pointers are $clog2(DEPTH)+1 bits wide; the MSB distinguishes full from empty.
- `full` = pointer LSBs equal and MSBs differ. `empty` = pointers equal.
- Push: the record is written at the write pointer when `if_push_valid && if_push_ready`; the write pointer increments.
- Resolve: a valid resolve with the queue non-empty pops the head record.
- Mispredict on resolve = (`pred_taken != ex_taken`) OR (`ex_taken && pred_target != ex_target`).
- Correct PC on resolve = `ex_taken ? ex_target : pc + 32'd4`, with 32-bit wrap.
- Training: every accepted resolve drives `ex_update_en`=1 with `ex_actual_taken`=`ex_taken` and `pht_idx_ex`=head pht_idx. Training happens whether or not the branch mispredicted.
- Mispredict: `redirect_valid`=1 and `redirect_pc`=correct PC. The queue is emptied: both pointers are set to the post-pop read pointer value.
- Same-cycle push and resolve:
  - Correct resolve: both the push and the pop take effect; count is unchanged. This is legal even when full, but ready stays `!full` and does not consider the pop.
  - Mispredict: the push is discarded, since it is on the wrong path.
- `ext_flush`: pointers are equalized and no update is generated. A resolve in the same cycle is dropped; flush has priority over resolve.
- Resolve while empty: no update and no redirect; `resolve_err` is set and stays set until reset.
- Reset: pointers 0, count 0, all outputs 0, `resolve_err` 0, `if_push_ready` 1. The record contents need no reset.

## Timing
- Push is visible in `count` the cycle after acceptance.
- Resolve-to-output latency is 1 cycle: `ex_update_en`, `ex_actual_taken`, `pht_idx_ex`, `redirect_valid` and `redirect_pc` are registered.
- `ex_update_en` and `redirect_valid` are single-cycle pulses.
- A record pushed in cycle N can be resolved in cycle N+1 at the earliest. There is no push-to-resolve bypass.
- `rst_n` low mid-operation: in-flight records are lost and any pending update or redirect pulse is suppressed on the next edge.
- Back-to-back resolves produce back-to-back update pulses.

## Configuration
- `BRQ_PERF_EN` defined:
  - adds outputs `perf_branches` and `perf_mispredicts`, each 32 bits;
  - each counts accepted resolves or mispredicts respectively, saturates at 32'hFFFF_FFFF, and resets to 0.
- `BRQ_PERF_EN` undefined: neither the ports nor the counters exist, and all other behaviour is identical.

## Test plan
- Push pc=0x100, taken, idx=5, target=0x200, then resolve taken with target 0x200 -> next cycle: update_en=1, taken=1, idx=5; redirect_valid=0; count=0.
- Push pc=0x100, not taken, idx=3, then resolve taken with target 0x180 -> update idx=3, taken=1; redirect_valid=1, redirect_pc=0x180; queue empty.
- Push 4 records with DEPTH=4 -> ready=0 and a 5th push is ignored. Resolve the first correctly while pushing a 6th -> count stays 4 and the pointers wrap.
- Push 3 records, mispredict the first with a same-cycle push -> count=0 and the pushed record is discarded. The following resolve sets resolve_err=1 with no update.
- `ext_flush` together with a resolve on 2 entries -> count=0 and no update_en.
- Reset asserted mid-stream -> all outputs 0, ready=1. With `BRQ_PERF_EN`: 3 resolves and 1 mispredict -> perf_branches=3, perf_mispredicts=1.
